// File: rtl/bullet_sched.sv
// Bullet slot scheduler: one move sweep per frame tick over a fixed slot pool,
// then a single spawn cycle, plus a registered per-pixel bullet coverage query.
module bullet_sched #(
    parameter int SLOTS    = 8,
    parameter int X_W      = 11,
    parameter int Y_W      = 10,
    parameter int SPEED    = 4,
    parameter int COOLDOWN = 8,
    parameter int BUL_W    = 4,
    parameter int BUL_H    = 8,
    parameter int GUN_OFF  = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_tick_i,
    input  logic             fire_i,
    input  logic             mode_i,
    input  logic [X_W-1:0]   me_x_pos_i,
    input  logic [Y_W-1:0]   me_y_pos_i,
    input  logic [X_W-1:0]   req_x_addr_i,
    input  logic [Y_W-1:0]   req_y_addr_i,
    output logic             busy_o,
    output logic [SLOTS-1:0] active_o,
    output logic             overrun_o,
    output logic             vga_alpha_o
);

    localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    typedef enum logic [1:0] {IDLE, MOVE, SPAWN} state_t;

    state_t           state_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [CD_W-1:0]  cd_reg;
    logic             fire_reg;
    logic             mode_reg;
    logic             cd_zero_reg;
    logic             busy_reg;
    logic             overrun_reg;
    logic             alpha_reg;

    logic             valid_reg [SLOTS];
    logic [X_W-1:0]   x_reg     [SLOTS];
    logic [Y_W-1:0]   y_reg     [SLOTS];

    logic [SLOTS-1:0] hit;
    logic [SLOTS-1:0] active;

    // Lowest two free slots, used by the spawn cycle.
    logic             first_found;
    logic             second_found;
    logic [IDX_W-1:0] first_idx;
    logic [IDX_W-1:0] second_idx;

    always_comb begin
        first_found  = 1'b0;
        second_found = 1'b0;
        first_idx    = '0;
        second_idx   = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (!valid_reg[i]) begin
                if (!first_found) begin
                    first_found = 1'b1;
                    first_idx   = IDX_W'(i);
                end else if (!second_found) begin
                    second_found = 1'b1;
                    second_idx   = IDX_W'(i);
                end
            end
        end
    end

    // Spawn x values wrap to X_W bits, matching the truncated stored x.
    logic [X_W-1:0] gun_x;
    logic [X_W-1:0] right_x;
    logic [Y_W-1:0] spawn_y;
    logic           y_ok;
    logic           spawn_ok;

    assign gun_x    = me_x_pos_i + X_W'(GUN_OFF);
    assign right_x  = me_x_pos_i + X_W'(2 * GUN_OFF);
    assign spawn_y  = me_y_pos_i - Y_W'(BUL_H);
    assign y_ok     = (me_y_pos_i >= Y_W'(BUL_H));
    assign spawn_ok = fire_reg && cd_zero_reg && y_ok &&
                      (mode_reg ? second_found : first_found);

    // Hit tests are one bit wider than the coordinates so x + BUL_W never wraps.
    genvar gi;
    generate
        for (gi = 0; gi < SLOTS; gi++) begin : g_slot
            logic [X_W:0] x_lo;
            logic [Y_W:0] y_lo;
            logic [X_W:0] qx;
            logic [Y_W:0] qy;
            assign x_lo       = {1'b0, x_reg[gi]};
            assign y_lo       = {1'b0, y_reg[gi]};
            assign qx         = {1'b0, req_x_addr_i};
            assign qy         = {1'b0, req_y_addr_i};
            assign hit[gi]    = valid_reg[gi] &&
                                (qx >= x_lo) && (qx < x_lo + (X_W+1)'(BUL_W)) &&
                                (qy >= y_lo) && (qy < y_lo + (Y_W+1)'(BUL_H));
            assign active[gi] = valid_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            cd_reg      <= '0;
            fire_reg    <= 1'b0;
            mode_reg    <= 1'b0;
            cd_zero_reg <= 1'b0;
            busy_reg    <= 1'b0;
            overrun_reg <= 1'b0;
            alpha_reg   <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                valid_reg[i] <= 1'b0;
                x_reg[i]     <= '0;
                y_reg[i]     <= '0;
            end
        end else begin
            overrun_reg <= frame_tick_i && (state_reg != IDLE);
            alpha_reg   <= |hit;
            case (state_reg)
                IDLE: begin
                    if (frame_tick_i) begin
                        fire_reg    <= fire_i;
                        mode_reg    <= mode_i;
                        // A shot is allowed only if the cooldown had already expired at this tick.
                        cd_zero_reg <= (cd_reg == '0);
                        if (cd_reg != '0) begin
                            cd_reg <= cd_reg - CD_W'(1);
                        end
                        idx_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= MOVE;
                    end
                end
                MOVE: begin
                    if (valid_reg[idx_reg]) begin
                        if (y_reg[idx_reg] < Y_W'(SPEED)) begin
                            valid_reg[idx_reg] <= 1'b0;
                        end else begin
                            y_reg[idx_reg] <= y_reg[idx_reg] - Y_W'(SPEED);
                        end
                    end
                    if (idx_reg == IDX_W'(SLOTS - 1)) begin
                        state_reg <= SPAWN;
                    end else begin
                        idx_reg <= idx_reg + IDX_W'(1);
                    end
                end
                SPAWN: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    if (spawn_ok) begin
                        cd_reg               <= CD_W'(COOLDOWN);
                        valid_reg[first_idx] <= 1'b1;
                        y_reg[first_idx]     <= spawn_y;
                        if (mode_reg) begin
                            x_reg[first_idx]      <= me_x_pos_i;
                            valid_reg[second_idx] <= 1'b1;
                            x_reg[second_idx]     <= right_x;
                            y_reg[second_idx]     <= spawn_y;
                        end else begin
                            x_reg[first_idx] <= gun_x;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o      = busy_reg;
    assign active_o    = active;
    assign overrun_o   = overrun_reg;
    assign vga_alpha_o = alpha_reg;

endmodule

// File: tb/tb_bullet_sched.sv
// Directed bench for bullet_sched: tick/query vector tables plus hand-written
// sequences for sweep timing, overrun, retire and mid-sweep reset.
module tb_bullet_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_tick_i = 1'b0;
    logic        fire_i = 1'b0;
    logic        mode_i = 1'b0;
    logic [10:0] me_x_pos_i = '0;
    logic [9:0]  me_y_pos_i = '0;
    logic [10:0] req_x_addr_i = '0;
    logic [9:0]  req_y_addr_i = '0;
    logic        busy_o;
    logic [7:0]  active_o;
    logic        overrun_o;
    logic        vga_alpha_o;

    always #5 clk = ~clk;

    bullet_sched dut (
        .clk          (clk),
        .rst          (rst),
        .frame_tick_i (frame_tick_i),
        .fire_i       (fire_i),
        .mode_i       (mode_i),
        .me_x_pos_i   (me_x_pos_i),
        .me_y_pos_i   (me_y_pos_i),
        .req_x_addr_i (req_x_addr_i),
        .req_y_addr_i (req_y_addr_i),
        .busy_o       (busy_o),
        .active_o     (active_o),
        .overrun_o    (overrun_o),
        .vga_alpha_o  (vga_alpha_o)
    );

    typedef struct {
        logic        fire;
        logic        mode;
        logic [10:0] mx;
        logic [9:0]  my;
        logic [7:0]  exp_act;
    } tick_vec_t;

    typedef struct {
        logic [10:0] qx;
        logic [9:0]  qy;
        logic        exp_alpha;
    } query_vec_t;

    int tests = 0;
    int fails = 0;

    logic       busy_h [0:15];
    logic       ovr_h  [0:15];
    logic [7:0] act_h  [0:15];

    tick_vec_t  tv  [65];
    query_vec_t qv1 [7];
    query_vec_t qv2 [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 40 && busy_o; c++) @(negedge clk);
        if (busy_o) check("idle_timeout", 32'(busy_o), 32'd0);
    endtask

    task automatic do_tick(input logic f, input logic m, input logic [10:0] mx, input logic [9:0] my);
        wait_idle();
        @(negedge clk);
        frame_tick_i = 1'b1;
        fire_i = f;
        mode_i = m;
        me_x_pos_i = mx;
        me_y_pos_i = my;
        @(negedge clk);
        frame_tick_i = 1'b0;
        wait_idle();
    endtask

    // Record outputs at each negedge k after a tick; optional extra tick / reset at given k.
    task automatic watch(input logic f, input logic m, input logic [10:0] mx, input logic [9:0] my,
                         input int t2, input int ra, input int rr);
        wait_idle();
        @(negedge clk);
        frame_tick_i = 1'b1;
        fire_i = f;
        mode_i = m;
        me_x_pos_i = mx;
        me_y_pos_i = my;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            busy_h[k] = busy_o;
            act_h[k]  = active_o;
            ovr_h[k]  = overrun_o;
            frame_tick_i = (k == t2);
            if (k == ra) rst = 1'b0;
            if (k == rr) rst = 1'b1;
        end
        frame_tick_i = 1'b0;
        $display("[TB] watched tick fire=%0b mode=%0b me=(%0d,%0d)", f, m, mx, my);
    endtask

    task automatic query(input logic [10:0] qx, input logic [9:0] qy, input logic exp, input string name);
        @(negedge clk);
        req_x_addr_i = qx;
        req_y_addr_i = qy;
        @(negedge clk);
        $display("[TB] query (%0d,%0d) alpha=%0b", qx, qy, vga_alpha_o);
        check(name, 32'(vga_alpha_o), 32'(exp));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Vector tables.
        qv1[0] = '{11'd115, 10'd495, 1'b1};
        qv1[1] = '{11'd118, 10'd495, 1'b0};
        qv1[2] = '{11'd114, 10'd492, 1'b1};
        qv1[3] = '{11'd117, 10'd499, 1'b1};
        qv1[4] = '{11'd113, 10'd495, 1'b0};
        qv1[5] = '{11'd114, 10'd500, 1'b0};
        qv1[6] = '{11'd114, 10'd491, 1'b0};

        qv2[0] = '{11'd300, 10'd392, 1'b1};
        qv2[1] = '{11'd303, 10'd399, 1'b1};
        qv2[2] = '{11'd304, 10'd392, 1'b0};
        qv2[3] = '{11'd328, 10'd392, 1'b1};
        qv2[4] = '{11'd331, 10'd399, 1'b1};
        qv2[5] = '{11'd332, 10'd392, 1'b0};
        qv2[6] = '{11'd314, 10'd395, 1'b0};
        qv2[7] = '{11'd300, 10'd400, 1'b0};
        qv2[8] = '{11'd300, 10'd391, 1'b0};

        // Fire held for 65 ticks: shots on ticks 1,10,...,55 fill slots 0..6; slot 0
        // starts at y=252 so it retires on tick 65; tick 64 double fails (one free slot),
        // tick 65 double succeeds into slots 0 and 7.
        for (int i = 0; i < 65; i++) begin
            int k;
            int n;
            k = i + 1;
            n = (k >= 55) ? 7 : ((k - 1) / 9 + 1);
            tv[i].fire    = 1'b1;
            tv[i].mode    = (k >= 64);
            tv[i].mx      = (k == 65) ? 11'd300 : 11'd100;
            tv[i].my      = (k == 1) ? 10'd260 : ((k == 65) ? 10'd400 : 10'd500);
            tv[i].exp_act = (k == 65) ? 8'hFF : 8'((1 << n) - 1);
        end

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_active", 32'(active_o), 32'd0);
        check("rst_overrun", 32'(overrun_o), 32'd0);
        check("rst_alpha", 32'(vga_alpha_o), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_active", 32'(active_o), 32'd0);

        // Single spawn with sweep timing.
        watch(1'b1, 1'b0, 11'd100, 10'd500, -1, -1, -1);
        check("spawn_busy_k1", 32'(busy_h[1]), 32'd1);
        check("spawn_busy_k9", 32'(busy_h[9]), 32'd1);
        check("spawn_busy_k10", 32'(busy_h[10]), 32'd0);
        check("spawn_act_k9", 32'(act_h[9]), 32'd0);
        check("spawn_act_k10", 32'(act_h[10]), 32'h01);
        for (int i = 0; i < 7; i++) query(qv1[i].qx, qv1[i].qy, qv1[i].exp_alpha, $sformatf("q1_%0d", i));

        // Move one frame, then march slot 0 down to y=0 and retire it.
        do_tick(1'b0, 1'b0, 11'd100, 10'd500);
        query(11'd114, 10'd488, 1'b1, "move_top");
        query(11'd114, 10'd495, 1'b1, "move_bottom");
        query(11'd114, 10'd496, 1'b0, "move_below");
        repeat (122) do_tick(1'b0, 1'b0, 11'd100, 10'd500);
        check("y0_active", 32'(active_o), 32'h01);
        query(11'd114, 10'd0, 1'b1, "y0_top");
        query(11'd114, 10'd8, 1'b0, "y0_below");
        watch(1'b0, 1'b0, 11'd100, 10'd500, -1, -1, -1);
        check("retire_act_k1", 32'(act_h[1]), 32'h01);
        check("retire_act_k2", 32'(act_h[2]), 32'h00);
        query(11'd114, 10'd0, 1'b0, "retired_gone");

        // Cooldown and double shot with slot scarcity.
        do_reset();
        for (int i = 0; i < 65; i++) begin
            do_tick(tv[i].fire, tv[i].mode, tv[i].mx, tv[i].my);
            $display("[TB] tick %0d fire=%0b mode=%0b active=%02h", i + 1, tv[i].fire, tv[i].mode, active_o);
            check($sformatf("tick%0d_active", i + 1), 32'(active_o), 32'(tv[i].exp_act));
        end
        for (int i = 0; i < 9; i++) query(qv2[i].qx, qv2[i].qy, qv2[i].exp_alpha, $sformatf("q2_%0d", i));

        // Overrun during a sweep and the me_y < BUL_H boundary.
        do_reset();
        watch(1'b1, 1'b0, 11'd100, 10'd5, 3, -1, -1);
        check("ovr_k3", 32'(ovr_h[3]), 32'd0);
        check("ovr_k4", 32'(ovr_h[4]), 32'd1);
        check("ovr_k5", 32'(ovr_h[5]), 32'd0);
        check("ovr_busy_k9", 32'(busy_h[9]), 32'd1);
        check("ovr_busy_k10", 32'(busy_h[10]), 32'd0);
        check("low_y_no_spawn", 32'(act_h[10]), 32'd0);
        // me_y == BUL_H spawns at y=0; a tick on the return-to-IDLE cycle is accepted.
        watch(1'b1, 1'b0, 11'd100, 10'd8, 10, -1, -1);
        check("edge_y_spawn", 32'(act_h[10]), 32'h01);
        check("back2back_busy", 32'(busy_h[11]), 32'd1);
        check("back2back_no_ovr", 32'(ovr_h[11]), 32'd0);
        wait_idle();
        check("back2back_retire", 32'(active_o), 32'd0);

        // x truncation, then reset mid-sweep with three live slots.
        do_reset();
        do_tick(1'b1, 1'b1, 11'd2040, 10'd500);
        check("wrap_double_act", 32'(active_o), 32'h03);
        repeat (8) do_tick(1'b1, 1'b0, 11'd2040, 10'd500);
        check("wrap_cooldown_act", 32'(active_o), 32'h03);
        do_tick(1'b1, 1'b0, 11'd2040, 10'd500);
        check("wrap_single_act", 32'(active_o), 32'h07);
        query(11'd2043, 10'd456, 1'b1, "wrap_left_edge");
        query(11'd2044, 10'd456, 1'b0, "wrap_left_past");
        query(11'd20, 10'd460, 1'b1, "wrap_right");
        query(11'd6, 10'd495, 1'b1, "wrap_gun");
        query(11'd9, 10'd499, 1'b1, "wrap_gun_corner");
        query(11'd10, 10'd492, 1'b0, "wrap_gun_past");
        watch(1'b0, 1'b0, 11'd100, 10'd500, -1, 4, 6);
        check("midrst_act_k4", 32'(act_h[4]), 32'h07);
        check("midrst_act_k5", 32'(act_h[5]), 32'h00);
        check("midrst_busy_k5", 32'(busy_h[5]), 32'd0);
        check("midrst_busy_k8", 32'(busy_h[8]), 32'd0);
        query(11'd6, 10'd495, 1'b0, "midrst_alpha");
        watch(1'b1, 1'b0, 11'd100, 10'd500, -1, -1, -1);
        check("after_rst_busy_k1", 32'(busy_h[1]), 32'd1);
        check("after_rst_busy_k9", 32'(busy_h[9]), 32'd1);
        check("after_rst_busy_k10", 32'(busy_h[10]), 32'd0);
        check("after_rst_act_k10", 32'(act_h[10]), 32'h01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
